// File: rtl/axil_lfsr_mgen_if.sv
// Bus bundle for axil_lfsr_mgen: AXI4-Lite configuration port plus the
// AXI4-Stream output. The generator uses the slave view; the driver of the
// register port and consumer of the stream uses the master view.
interface axil_lfsr_mgen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready, tready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
           tdata, tdest, tlast, tvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready, tready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
           tdata, tdest, tlast, tvalid
  );
endinterface

// File: rtl/axil_lfsr_mgen.sv
// Multi-channel Galois LFSR pattern generator. Configured over AXI4-Lite,
// emits round-robin interleaved words on AXI4-Stream with TDEST = channel and
// optional fixed-length bursts closed by TLAST.
module axil_lfsr_mgen #(
  parameter int          C_AXIL_DATA_WIDTH = 32,
  parameter int          C_AXIL_ADDR_WIDTH = 8,
  parameter int          LFSR_WIDTH        = 16,
  parameter int          NUM_CH            = 4,
  parameter logic [31:0] TAPS_RST          = 32'h0000_B400
) (
  input logic             aclk,
  input logic             areset,
  axil_lfsr_mgen_if.slave bus
);
  localparam int DW     = C_AXIL_DATA_WIDTH;
  localparam int LW     = LFSR_WIDTH;
  localparam int DEST_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   ch_en_reg, en_act_reg;
  logic [DW-1:0]       burst_len_reg, beat_cnt_reg;
  logic [LW-1:0]       seed_reg [NUM_CH];
  logic [LW-1:0]       taps_reg [NUM_CH];
  logic [LW-1:0]       taps_act_reg [NUM_CH];
  logic [LW-1:0]       lfsr_reg [NUM_CH];
  logic [DEST_W-1:0]   sel_reg;
  logic                done_reg, stop_pend_reg;
  logic                bvalid_reg, rvalid_reg;
  logic [1:0]          bresp_reg, rresp_reg;
  logic [DW-1:0]       rdata_reg;

  logic [C_AXIL_ADDR_WIDTH-1:0] awaddr_w, araddr_w;
  logic [31:0]   wa, ra;
  logic          wr_hs, rd_hs, start_req, stop_req, run, beat_hs, tlast_c;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] cur_lfsr;

  function automatic logic addr_mapped(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    if (a[1:0] == 2'b00) begin
      if (a <= 32'h10) ok = 1'b1;
      if (a >= 32'h20 && a < 32'h20 + 32'(8 * NUM_CH)) ok = 1'b1;
      if (a >= 32'h80 && a < 32'h80 + 32'(4 * NUM_CH)) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [LW-1:0] galois(input logic [LW-1:0] s, input logic [LW-1:0] t);
    return (s >> 1) ^ (s[0] ? t : '0);
  endfunction

  function automatic logic [DEST_W-1:0] first_ch(input logic [NUM_CH-1:0] en);
    logic [DEST_W-1:0] r;
    r = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) if (en[c]) r = DEST_W'(c);
    return r;
  endfunction

  // Next enabled channel strictly above cur, wrapping to the lowest enabled one.
  function automatic logic [DEST_W-1:0] next_ch(input logic [NUM_CH-1:0] en,
                                                input logic [DEST_W-1:0] cur);
    logic [DEST_W-1:0] low, above;
    logic              has_above;
    low = cur;
    above = cur;
    has_above = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (en[c]) begin
        low = DEST_W'(c);
        if (c > int'(cur)) begin
          above = DEST_W'(c);
          has_above = 1'b1;
        end
      end
    end
    return has_above ? above : low;
  endfunction

  assign awaddr_w  = bus.awaddr;
  assign araddr_w  = bus.araddr;
  assign wa        = 32'(awaddr_w);
  assign ra        = 32'(araddr_w);
  assign wr_hs     = bus.awvalid && bus.wvalid && !bvalid_reg;
  assign rd_hs     = bus.arvalid && !rvalid_reg;
  // STOP wins over START when both are set in one CTRL write.
  assign stop_req  = wr_hs && (wa == 32'h00) && bus.wdata[1];
  assign start_req = wr_hs && (wa == 32'h00) && bus.wdata[0] && !bus.wdata[1];
  assign run       = (state_reg == ST_RUN);
  assign beat_hs   = run && bus.tready;
  assign tlast_c   = run && (burst_len_reg != '0) && (beat_cnt_reg == burst_len_reg - 1'b1);

  assign bus.awready = wr_hs;
  assign bus.wready  = wr_hs;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = rd_hs;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.tvalid  = run;
  assign bus.tdata   = run ? DW'(cur_lfsr) : '0;
  assign bus.tdest   = run ? sel_reg : '0;
  assign bus.tlast   = tlast_c;

  // Select the live state of the channel currently presented on the stream.
  always_comb begin
    cur_lfsr = '0;
    for (int c = 0; c < NUM_CH; c++) if (sel_reg == DEST_W'(c)) cur_lfsr = lfsr_reg[c];
  end

  // Read data mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_data = '0;
    if (ra == 32'h04) rd_data = DW'({done_reg, state_reg != ST_IDLE});
    if (ra == 32'h08) rd_data = DW'(ch_en_reg);
    if (ra == 32'h0C) rd_data = burst_len_reg;
    if (ra == 32'h10) rd_data = beat_cnt_reg;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ra == 32'h20 + 32'(8 * c)) rd_data = DW'(seed_reg[c]);
      if (ra == 32'h24 + 32'(8 * c)) rd_data = DW'(taps_reg[c]);
      if (ra == 32'h80 + 32'(4 * c)) rd_data = DW'(lfsr_reg[c]);
    end
  end

  // AXI-Lite response channels and the configuration registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
      rvalid_reg    <= 1'b0;
      rresp_reg     <= RESP_OKAY;
      rdata_reg     <= '0;
      ch_en_reg     <= '1;
      burst_len_reg <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        seed_reg[c] <= LW'(1);
        taps_reg[c] <= TAPS_RST[LW-1:0];
      end
    end else begin
      if (wr_hs) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= addr_mapped(wa) ? RESP_OKAY : RESP_SLVERR;
        if (wa == 32'h08) ch_en_reg <= bus.wdata[NUM_CH-1:0];
        if (wa == 32'h0C) burst_len_reg <= bus.wdata;
        for (int c = 0; c < NUM_CH; c++) begin
          if (wa == 32'h20 + 32'(8 * c)) seed_reg[c] <= bus.wdata[LW-1:0];
          if (wa == 32'h24 + 32'(8 * c)) taps_reg[c] <= bus.wdata[LW-1:0];
        end
      end else if (bus.bready) begin
        bvalid_reg <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= addr_mapped(ra) ? RESP_OKAY : RESP_SLVERR;
        rdata_reg  <= addr_mapped(ra) ? rd_data : '0;
      end else if (bus.rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge aclk) begin
    if (areset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Sequencer next state: a presented beat is only abandoned at its handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_req && ch_en_reg != '0) state_next = ST_LOAD;
      ST_LOAD: state_next = (stop_req || stop_pend_reg) ? ST_IDLE : ST_RUN;
      ST_RUN:  if (beat_hs && (tlast_c || stop_req || stop_pend_reg)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Channel datapath: seed load, per-beat LFSR advance, beat count and status.
  always_ff @(posedge aclk) begin
    if (areset) begin
      en_act_reg    <= '0;
      sel_reg       <= '0;
      beat_cnt_reg  <= '0;
      done_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr_reg[c]     <= '0;
        taps_act_reg[c] <= '0;
      end
    end else begin
      stop_pend_reg <= (state_next != ST_IDLE) &&
                       (stop_pend_reg || (stop_req && state_reg != ST_IDLE));
      if (state_reg == ST_LOAD) begin
        for (int c = 0; c < NUM_CH; c++) begin
          lfsr_reg[c]     <= (seed_reg[c] == '0) ? LW'(1) : seed_reg[c];
          taps_act_reg[c] <= taps_reg[c];
        end
        en_act_reg   <= ch_en_reg;
        sel_reg      <= first_ch(ch_en_reg);
        beat_cnt_reg <= '0;
        done_reg     <= 1'b0;
      end else if (beat_hs) begin
        for (int c = 0; c < NUM_CH; c++)
          if (sel_reg == DEST_W'(c)) lfsr_reg[c] <= galois(lfsr_reg[c], taps_act_reg[c]);
        if (beat_cnt_reg != '1) beat_cnt_reg <= beat_cnt_reg + 1'b1;
        sel_reg <= next_ch(en_act_reg, sel_reg);
        if (tlast_c) done_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axil_lfsr_mgen.sv
// Directed bench for axil_lfsr_mgen: register access, single/interleaved
// bursts, backpressure, STOP, error responses and mid-burst reset.
module tb_axil_lfsr_mgen;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axil_lfsr_mgen_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEST_WIDTH(2)) bus ();

  axil_lfsr_mgen #(
    .C_AXIL_DATA_WIDTH(32), .C_AXIL_ADDR_WIDTH(8), .LFSR_WIDTH(16),
    .NUM_CH(4), .TAPS_RST(32'h0000_B400)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_data [8];
  logic [1:0]  exp_dest [8];
  logic        exp_last [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axil_wr(input logic [7:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
    bit hs = 0;
    bit bd = 0;
    logic [1:0] resp = 2'bxx;
    @(negedge aclk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      #1;
      if (bus.awready === 1'b1 && bus.wready === 1'b1) hs = 1;
      else @(negedge aclk);
    end
    if (hs) @(posedge aclk);
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    for (int i = 0; i < 20 && !bd; i++) begin
      if (bus.bvalid === 1'b1) begin
        resp = bus.bresp;
        bd = 1;
        @(posedge aclk);
      end else @(negedge aclk);
    end
    @(negedge aclk);
    bus.bready = 1'b0;
    $display("wr addr=0x%02h data=0x%08h bresp=%b", a, d, resp);
    chk($sformatf("wr_hs_%02h", a), 32'(hs & bd), 32'd1);
    chk($sformatf("bresp_%02h", a), 32'(resp), 32'(exp_resp));
  endtask

  task automatic axil_rd(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    bit hs = 0;
    bit rd = 0;
    logic [31:0] data = 'x;
    logic [1:0] resp = 2'bxx;
    @(negedge aclk);
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      #1;
      if (bus.arready === 1'b1) hs = 1;
      else @(negedge aclk);
    end
    if (hs) @(posedge aclk);
    @(negedge aclk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    for (int i = 0; i < 20 && !rd; i++) begin
      if (bus.rvalid === 1'b1) begin
        data = bus.rdata; resp = bus.rresp;
        rd = 1;
        @(posedge aclk);
      end else @(negedge aclk);
    end
    @(negedge aclk);
    bus.rready = 1'b0;
    $display("rd addr=0x%02h data=0x%08h rresp=%b", a, data, resp);
    chk($sformatf("rd_hs_%02h", a), 32'(hs & rd), 32'd1);
    chk($sformatf("rdata_%02h", a), data, exp_d);
    chk($sformatf("rresp_%02h", a), 32'(resp), 32'(exp_resp));
  endtask

  // Consume n beats, checking each against exp_* and holding values across stalls.
  task automatic run_stream(input string name, input int n, input bit rnd);
    int got = 0;
    bit stalled = 0;
    bit rdy;
    logic [31:0] hd;
    logic [1:0]  hdst;
    logic        hl;
    for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
      @(negedge aclk);
      if (stalled) begin
        chk({name, "_stall_tvalid"}, 32'(bus.tvalid), 32'd1);
        chk({name, "_stall_tdata"}, bus.tdata, hd);
        chk({name, "_stall_tdest"}, 32'(bus.tdest), 32'(hdst));
        chk({name, "_stall_tlast"}, 32'(bus.tlast), 32'(hl));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tready = rdy;
      stalled = 0;
      if (bus.tvalid === 1'b1) begin
        if (rdy) begin
          $display("%s beat=%0d tdest=%0d tdata=0x%08h tlast=%b", name, got, bus.tdest, bus.tdata, bus.tlast);
          chk($sformatf("%s_b%0d_tdata", name, got), bus.tdata, exp_data[got]);
          chk($sformatf("%s_b%0d_tdest", name, got), 32'(bus.tdest), 32'(exp_dest[got]));
          chk($sformatf("%s_b%0d_tlast", name, got), 32'(bus.tlast), 32'(exp_last[got]));
          got++;
        end else begin
          stalled = 1;
          hd = bus.tdata; hdst = bus.tdest; hl = bus.tlast;
        end
      end
    end
    chk({name, "_beats"}, 32'(got), 32'(n));
    @(negedge aclk);
    bus.tready = 1'b0;
    chk({name, "_tvalid_after"}, 32'(bus.tvalid), 32'd0);
  endtask

  task automatic set_exp(input int i, input logic [1:0] dst, input logic [31:0] d, input logic l);
    exp_dest[i] = dst; exp_data[i] = d; exp_last[i] = l;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0; bus.tready = 0;

    // Reset state
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 32'(bus.tvalid), 32'd0);
    chk("rst_tdata", bus.tdata, 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    areset = 1'b0;
    axil_rd(8'h08, 32'h0000_000F, 2'b00);
    axil_rd(8'h24, 32'h0000_B400, 2'b00);
    axil_rd(8'h0C, 32'h0, 2'b00);
    axil_rd(8'h04, 32'h0, 2'b00);
    axil_rd(8'h20, 32'h1, 2'b00);

    // Single channel burst of 4
    axil_wr(8'h08, 32'h1, 2'b00);
    axil_wr(8'h20, 32'h0001, 2'b00);
    axil_wr(8'h24, 32'hB400, 2'b00);
    axil_wr(8'h0C, 32'd4, 2'b00);
    set_exp(0, 2'd0, 32'h0001, 1'b0);
    set_exp(1, 2'd0, 32'hB400, 1'b0);
    set_exp(2, 2'd0, 32'h5A00, 1'b0);
    set_exp(3, 2'd0, 32'h2D00, 1'b1);
    axil_wr(8'h00, 32'h1, 2'b00);
    run_stream("single", 4, 1'b0);
    axil_rd(8'h04, 32'h2, 2'b00);
    axil_rd(8'h10, 32'd4, 2'b00);
    axil_rd(8'h80, 32'h1680, 2'b00);

    // Interleave channels 0 and 2
    axil_wr(8'h08, 32'h5, 2'b00);
    axil_wr(8'h30, 32'h00FF, 2'b00);
    set_exp(0, 2'd0, 32'h0001, 1'b0);
    set_exp(1, 2'd2, 32'h00FF, 1'b0);
    set_exp(2, 2'd0, 32'hB400, 1'b0);
    set_exp(3, 2'd2, 32'hB47F, 1'b1);
    axil_wr(8'h00, 32'h1, 2'b00);
    run_stream("ileave", 4, 1'b0);

    // Backpressure on the single-channel scenario
    axil_wr(8'h08, 32'h1, 2'b00);
    set_exp(0, 2'd0, 32'h0001, 1'b0);
    set_exp(1, 2'd0, 32'hB400, 1'b0);
    set_exp(2, 2'd0, 32'h5A00, 1'b0);
    set_exp(3, 2'd0, 32'h2D00, 1'b1);
    axil_wr(8'h00, 32'h1, 2'b00);
    run_stream("bp", 4, 1'b1);
    axil_rd(8'h10, 32'd4, 2'b00);

    // STOP in free-run while stalled
    axil_wr(8'h0C, 32'd0, 2'b00);
    axil_wr(8'h00, 32'h1, 2'b00);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge aclk);
      if (bus.tvalid === 1'b1) seen = 1;
    end
    chk("stop_tvalid_up", 32'(seen), 32'd1);
    repeat (3) @(negedge aclk);
    axil_wr(8'h00, 32'h2, 2'b00);
    @(negedge aclk);
    chk("stop_beat_held", 32'(bus.tvalid), 32'd1);
    chk("stop_tlast", 32'(bus.tlast), 32'd0);
    chk("stop_tdata", bus.tdata, 32'h0001);
    bus.tready = 1'b1;
    @(negedge aclk);
    bus.tready = 1'b0;
    chk("stop_tvalid_down", 32'(bus.tvalid), 32'd0);
    axil_rd(8'h04, 32'h0, 2'b00);
    axil_rd(8'h10, 32'd1, 2'b00);

    // Error responses
    axil_rd(8'hFC, 32'h0, 2'b10);
    axil_wr(8'h48, 32'h1234, 2'b10);
    axil_rd(8'h60, 32'h0, 2'b10);

    // Zero seed loads as 1; one-beat burst
    axil_wr(8'h20, 32'h0, 2'b00);
    axil_wr(8'h0C, 32'd1, 2'b00);
    set_exp(0, 2'd0, 32'h0001, 1'b1);
    axil_wr(8'h00, 32'h1, 2'b00);
    run_stream("zseed", 1, 1'b0);
    axil_rd(8'h04, 32'h2, 2'b00);

    // START with no channels enabled is ignored
    axil_wr(8'h08, 32'h0, 2'b00);
    axil_wr(8'h00, 32'h1, 2'b00);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (bus.tvalid !== 1'b0) seen = 1;
    end
    chk("noen_tvalid", 32'(seen), 32'd0);
    axil_rd(8'h04, 32'h2, 2'b00);

    // Reset in the middle of a burst
    axil_wr(8'h08, 32'hF, 2'b00);
    axil_wr(8'h0C, 32'd100, 2'b00);
    axil_wr(8'h24, 32'h1234, 2'b00);
    axil_wr(8'h00, 32'h1, 2'b00);
    bus.tready = 1'b1;
    repeat (5) @(negedge aclk);
    chk("mid_tvalid", 32'(bus.tvalid), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    bus.tready = 1'b0;
    chk("mrst_tvalid", 32'(bus.tvalid), 32'd0);
    chk("mrst_tdata", bus.tdata, 32'd0);
    axil_rd(8'h08, 32'h0000_000F, 2'b00);
    axil_rd(8'h24, 32'h0000_B400, 2'b00);
    axil_rd(8'h3C, 32'h0000_B400, 2'b00);
    axil_rd(8'h10, 32'd0, 2'b00);
    axil_rd(8'h0C, 32'd0, 2'b00);
    axil_rd(8'h04, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
